// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared width, word type and reset value for the adder family
package adder_pkg;

  localparam int ADDER_W = 8;

  typedef logic [ADDER_W-1:0] adder_word_t;

  localparam adder_word_t ADDER_RST_SUM = '0;

endpackage

// File: rtl/full_adder_1_bit.sv
// rtl/full_adder_1_bit.sv - combinational one-bit full-adder cell
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half;

  assign half = a ^ b;
  assign s    = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/full_adder_8_bit.sv
// rtl/full_adder_8_bit.sv - registered 8-bit ripple-carry adder; FULL_ADDER_8_BIT_OVERFLOW_EN adds a signed-overflow flag
module full_adder_8_bit
  import adder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDER_W-1:0] A,
  input  logic [ADDER_W-1:0] B,
  input  logic              carry_in,
  output logic [ADDER_W-1:0] sum,
`ifdef FULL_ADDER_8_BIT_OVERFLOW_EN
  output logic              overflow,
`endif
  output logic              carry_out
);

  adder_word_t       s;
  logic [ADDER_W:0]  c;

  assign c[0] = carry_in;

  // Plain ripple chain: c[i+1] feeds cell i+1, no lookahead.
  for (genvar i = 0; i < ADDER_W; i++) begin : g_cell
    full_adder_1_bit u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= ADDER_RST_SUM;
      carry_out <= 1'b0;
    end else begin
      sum       <= s;
      carry_out <= c[ADDER_W];
    end
  end

`ifdef FULL_ADDER_8_BIT_OVERFLOW_EN
  // Carry into and out of the sign bit differ exactly on signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= c[ADDER_W] ^ c[ADDER_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_8_bit.sv
// tb/tb_full_adder_8_bit.sv - directed self-checking bench for full_adder_8_bit
module tb_full_adder_8_bit;

  logic       clk;
  logic       rst;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       carry_in;
  logic [7:0] sum;
  logic       carry_out;
`ifdef FULL_ADDER_8_BIT_OVERFLOW_EN
  logic       overflow;
`endif

  int tests;
  int fails;

  full_adder_8_bit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (a_in),
    .B         (b_in),
    .carry_in  (carry_in),
    .sum       (sum),
`ifdef FULL_ADDER_8_BIT_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply operands, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b, input logic ci);
    rst      = r;
    a_in     = a;
    b_in     = b;
    carry_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] s_exp, input logic co_exp);
    check({tag, ".sum"}, {1'b0, sum}, {1'b0, s_exp});
    check({tag, ".carry_out"}, {8'h00, carry_out}, {8'h00, co_exp});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    a_in = 8'h00;
    b_in = 8'h00;
    carry_in = 1'b0;
    #2;

    step(1'b1, 8'hFF, 8'hFF, 1'b1);
    expect_out("reset1", 8'h00, 1'b0);
    step(1'b1, 8'hFF, 8'hFF, 1'b1);
    expect_out("reset2", 8'h00, 1'b0);
`ifdef FULL_ADDER_8_BIT_OVERFLOW_EN
    check("reset2.overflow", {8'h00, overflow}, 9'h000);
`endif
    step(1'b0, 8'hFF, 8'hFF, 1'b1);
    expect_out("post_reset", 8'hFF, 1'b1);

    step(1'b0, 8'd4, 8'd4, 1'b0);
    expect_out("seq_4", 8'd8, 1'b0);
    step(1'b0, 8'd10, 8'd10, 1'b0);
    expect_out("seq_10", 8'd20, 1'b0);
    step(1'b0, 8'd15, 8'd15, 1'b0);
    expect_out("seq_15", 8'd30, 1'b0);
    step(1'b0, 8'd20, 8'd20, 1'b0);
    expect_out("seq_20", 8'd40, 1'b0);
    step(1'b0, 8'd30, 8'd30, 1'b0);
    expect_out("seq_30", 8'd60, 1'b0);

    step(1'b0, 8'd255, 8'd1, 1'b0);
    expect_out("wrap_255_1", 8'd0, 1'b1);
    step(1'b0, 8'd200, 8'd100, 1'b1);
    expect_out("wrap_200_100_c", 8'd45, 1'b1);
    step(1'b0, 8'hFF, 8'h00, 1'b1);
    expect_out("ripple_ff_cin", 8'h00, 1'b1);
    step(1'b0, 8'hAA, 8'h55, 1'b0);
    expect_out("alt_bits", 8'hFF, 1'b0);

    step(1'b1, 8'd50, 8'd50, 1'b0);
    expect_out("mid_reset", 8'd0, 1'b0);
    step(1'b0, 8'd60, 8'd60, 1'b0);
    expect_out("resume_60", 8'd120, 1'b0);
    step(1'b0, 8'd70, 8'd5, 1'b1);
    expect_out("resume_70", 8'd76, 1'b0);

    step(1'b0, 8'd127, 8'd1, 1'b0);
    expect_out("ovf_127_1", 8'h80, 1'b0);
`ifdef FULL_ADDER_8_BIT_OVERFLOW_EN
    check("ovf_127_1.overflow", {8'h00, overflow}, 9'h001);
`endif
    step(1'b0, 8'd128, 8'd128, 1'b0);
    expect_out("ovf_128_128", 8'h00, 1'b1);
`ifdef FULL_ADDER_8_BIT_OVERFLOW_EN
    check("ovf_128_128.overflow", {8'h00, overflow}, 9'h001);
`endif
    step(1'b0, 8'd100, 8'd27, 1'b0);
    expect_out("ovf_100_27", 8'd127, 1'b0);
`ifdef FULL_ADDER_8_BIT_OVERFLOW_EN
    check("ovf_100_27.overflow", {8'h00, overflow}, 9'h000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
